scale_line_fetch_ctrl: RTL and testbench

- Row scheduler for the scaler calculator. Each time the calculator raises wr_req for a destination row, this block works out which source rows that row needs (top and bottom, bilinear pair).
- It fetches any missing row from frame memory into one of two line-buffer slots, using a burst read handshake.
- Once both rows are resident, it pulses tran_done.
- It also exports the slot selects and the vertical fraction to the interpolation datapath.

---
 rtl/scale_line_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_scale_line_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scale_line_fetch_ctrl.sv
// Row scheduler for the scaler: maps each destination row to its bilinear source-row pair and
// keeps those rows resident in a two-slot line buffer, fetching misses over a burst read port.
module scale_line_fetch_ctrl #(
    parameter int unsigned       ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       LINE_STRIDE = 640,
    parameter int unsigned       FLOAT_LEN   = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_start,
    input  logic              wr_req,
    input  logic [10:0]       dst_row,
    input  logic [14:0]       y_scale,
    input  logic [10:0]       src_v_num,
    input  logic [10:0]       src_h_num,
    output logic              tran_done,
    output logic              top_slot,
    output logic              bot_slot,
    output logic [10:0]       fy,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [10:0]       rd_len,
    input  logic              rd_ack,
    input  logic              rd_valid,
    output logic              lb_we,
    output logic              lb_wslot,
    output logic [10:0]       lb_waddr,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StCheck,
        StFetchReq,
        StFetchData,
        StReady,
        StHold
    } state_e;

    localparam logic [25:0] FracMask = 26'((64'd1 << FLOAT_LEN) - 64'd1);

    state_e            state_q, state_d;
    logic [10:0]       row_a_q, row_a_d;
    logic [10:0]       row_b_q, row_b_d;
    logic [10:0]       fy_calc_q, fy_calc_d;
    logic [10:0]       tag_q [2];
    logic [10:0]       tag_d [2];
    logic [1:0]        tag_valid_q, tag_valid_d;
    logic              victim_q, victim_d;
    logic [10:0]       fetch_row_q, fetch_row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [10:0]       len_q, len_d;
    logic [10:0]       cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic              top_q, top_d;
    logic              bot_q, bot_d;
    logic [10:0]       fy_q, fy_d;

    // Row arithmetic, consumed only in StCalc.
    logic [25:0] prod;
    logic [25:0] sy_ext;
    logic [10:0] v_max;
    logic        clamped;
    logic [10:0] sy;
    logic [10:0] row_b_calc;
    logic [10:0] fy_raw;

    always_comb begin
        prod       = 26'(dst_row) * 26'(y_scale);
        sy_ext     = prod >> FLOAT_LEN;
        v_max      = src_v_num - 11'd1;
        clamped    = sy_ext > 26'(v_max);
        sy         = clamped ? v_max : sy_ext[10:0];
        fy_raw     = clamped ? 11'd0 : 11'(prod & FracMask);
        row_b_calc = (sy < v_max) ? sy + 11'd1 : sy;
    end

    // Residency lookup against the latched row pair.
    logic hit0_a, hit1_a, hit0_b, hit1_b;
    logic hit_a, hit_b;
    logic slot_a, slot_b;
    logic victim;

    always_comb begin
        hit0_a = tag_valid_q[0] && (tag_q[0] == row_a_q);
        hit1_a = tag_valid_q[1] && (tag_q[1] == row_a_q);
        hit0_b = tag_valid_q[0] && (tag_q[0] == row_b_q);
        hit1_b = tag_valid_q[1] && (tag_q[1] == row_b_q);
        hit_a  = hit0_a || hit1_a;
        hit_b  = hit0_b || hit1_b;
        slot_a = !hit0_a;
        slot_b = !hit0_b;
        // Slot 0 is reused unless it holds a row this destination row still needs.
        victim = (!tag_valid_q[0] || ((tag_q[0] != row_a_q) && (tag_q[0] != row_b_q))) ? 1'b0 : 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_a_q     <= '0;
            row_b_q     <= '0;
            fy_calc_q   <= '0;
            tag_q       <= '{default: '0};
            tag_valid_q <= '0;
            victim_q    <= 1'b0;
            fetch_row_q <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            top_q       <= 1'b0;
            bot_q       <= 1'b0;
            fy_q        <= '0;
        end else begin
            row_a_q     <= row_a_d;
            row_b_q     <= row_b_d;
            fy_calc_q   <= fy_calc_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            victim_q    <= victim_d;
            fetch_row_q <= fetch_row_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            fy_q        <= fy_d;
        end
    end

    logic        start_fetch;
    logic [10:0] miss_row;

    always_comb begin
        state_d     = state_q;
        row_a_d     = row_a_q;
        row_b_d     = row_b_q;
        fy_calc_d   = fy_calc_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        victim_d    = victim_q;
        fetch_row_d = fetch_row_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        top_d       = top_q;
        bot_d       = bot_q;
        fy_d        = fy_q;
        start_fetch = 1'b0;
        miss_row    = row_a_q;

        unique case (state_q)
            StIdle: begin
                if (wr_req) state_d = StCalc;
            end
            StCalc: begin
                row_a_d   = sy;
                row_b_d   = row_b_calc;
                fy_calc_d = fy_raw;
                state_d   = frame_start ? StIdle : StCheck;
            end
            StCheck: begin
                if (frame_start) begin
                    state_d = StIdle;
                end else if (!hit_a) begin
                    start_fetch = 1'b1;
                    miss_row    = row_a_q;
                end else if (!hit_b) begin
                    start_fetch = 1'b1;
                    miss_row    = row_b_q;
                end else begin
                    top_d   = slot_a;
                    bot_d   = slot_b;
                    fy_d    = fy_calc_q;
                    state_d = StReady;
                end
            end
            StFetchReq: begin
                // A grant wins over frame_start so that an accepted burst is always drained.
                if (rd_ack) begin
                    drain_d = frame_start;
                    state_d = StFetchData;
                end else if (frame_start) begin
                    state_d = StIdle;
                end
            end
            StFetchData: begin
                if (frame_start) drain_d = 1'b1;
                if (rd_valid) begin
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q == len_q - 11'd1) begin
                        if (drain_q || frame_start) begin
                            state_d = StIdle;
                        end else begin
                            tag_d[victim_q]       = fetch_row_q;
                            tag_valid_d[victim_q] = 1'b1;
                            state_d               = StCheck;
                        end
                    end
                end
            end
            StReady: begin
                state_d = StHold;
            end
            StHold: begin
                if (!wr_req) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_fetch) begin
            victim_d              = victim;
            tag_valid_d[victim]   = 1'b0;
            fetch_row_d           = miss_row;
            addr_d                = BASE_ADDR + ADDR_W'(miss_row) * ADDR_W'(LINE_STRIDE);
            len_d                 = src_h_num;
            cnt_d                 = '0;
            drain_d               = 1'b0;
            state_d               = StFetchReq;
        end

        if (frame_start) tag_valid_d = '0;
    end

    logic in_req;
    logic in_data;

    always_comb begin
        in_req    = (state_q == StFetchReq);
        in_data   = (state_q == StFetchData);
        busy      = (state_q != StIdle);
        tran_done = (state_q == StReady);
        top_slot  = top_q;
        bot_slot  = bot_q;
        fy        = fy_q;
        rd_req    = in_req;
        rd_addr   = in_req ? addr_q : '0;
        rd_len    = in_req ? len_q : '0;
        lb_we     = in_data && rd_valid && !drain_q && !frame_start;
        lb_wslot  = in_data ? victim_q : 1'b0;
        lb_waddr  = in_data ? cnt_q : '0;
    end

endmodule

// File: tb/tb_scale_line_fetch_ctrl.sv
// Directed bench for scale_line_fetch_ctrl: row pairing, slot reuse, clamping, read handshake
// stalls, frame_start drain and the wr_req level handshake.
module tb_scale_line_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_req = 1'b0;
    logic [10:0] dst_row = '0;
    logic [14:0] y_scale = '0;
    logic [10:0] src_v_num = '0;
    logic [10:0] src_h_num = '0;
    logic        tran_done;
    logic        top_slot;
    logic        bot_slot;
    logic [10:0] fy;
    logic        rd_req;
    logic [27:0] rd_addr;
    logic [10:0] rd_len;
    logic        rd_ack = 1'b0;
    logic        rd_valid = 1'b0;
    logic        lb_we;
    logic        lb_wslot;
    logic [10:0] lb_waddr;
    logic        busy;

    int total = 0;
    int bad = 0;
    int td_cnt = 0;

    scale_line_fetch_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .wr_req      (wr_req),
        .dst_row     (dst_row),
        .y_scale     (y_scale),
        .src_v_num   (src_v_num),
        .src_h_num   (src_h_num),
        .tran_done   (tran_done),
        .top_slot    (top_slot),
        .bot_slot    (bot_slot),
        .fy          (fy),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .lb_we       (lb_we),
        .lb_wslot    (lb_wslot),
        .lb_waddr    (lb_waddr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tran_done === 1'b1) td_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Memory model: wait for a request, stall the grant, then stream len beats with gaps.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_slot,
                         input int ack_dly, input int gap, input int fs_beat);
        int n = 0;
        int stall_err = 0;
        int we_cnt = 0;
        int waddr_err = 0;
        int spurious = 0;
        int len = 640;
        while (rd_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rd_req"}, 32'(rd_req), 1);
        if (rd_req !== 1'b1) return;
        chk({tag, "_rd_addr"}, 32'(rd_addr), exp_addr);
        chk({tag, "_rd_len"}, 32'(rd_len), 640);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (rd_req !== 1'b1 || 32'(rd_addr) !== exp_addr || rd_len !== 11'd640) stall_err++;
        end
        if (ack_dly > 0) chk({tag, "_stall_stable"}, 32'(stall_err), 0);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk({tag, "_rd_req_drop"}, 32'(rd_req), 0);
        for (int b = 0; b < len; b++) begin
            if (b == fs_beat) begin
                rd_valid    = 1'b0;
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
            for (int g = 0; g < gap; g++) begin
                rd_valid = 1'b0;
                #1;
                if (lb_we !== 1'b0) spurious++;
                @(negedge clk);
            end
            rd_valid = 1'b1;
            #1;
            if (b == 0) chk({tag, "_lb_wslot"}, 32'(lb_wslot), 32'(exp_slot));
            if (lb_we === 1'b1) we_cnt++;
            if (lb_waddr !== 11'(b)) waddr_err++;
            @(negedge clk);
        end
        rd_valid = 1'b0;
        chk({tag, "_we_beats"}, 32'(we_cnt), (fs_beat < 0) ? 640 : 32'(fs_beat));
        chk({tag, "_waddr_seq"}, 32'(waddr_err), 0);
        if (gap > 0) chk({tag, "_gap_we"}, 32'(spurious), 0);
    endtask

    // Called right after the final burst: CHECK now, READY one cycle later.
    task automatic done_after_fetch(input string tag, input logic t, input logic b,
                                    input logic [10:0] f);
        chk({tag, "_td_pre"}, 32'(tran_done), 0);
        @(negedge clk);
        chk({tag, "_td"}, 32'(tran_done), 1);
        chk({tag, "_top"}, 32'(top_slot), 32'(t));
        chk({tag, "_bot"}, 32'(bot_slot), 32'(b));
        chk({tag, "_fy"}, 32'(fy), 32'(f));
    endtask

    task automatic req_hit(input string tag, input logic [10:0] row, input logic t, input logic b,
                           input logic [10:0] f);
        dst_row = row;
        wr_req  = 1'b1;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(tran_done), 0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(tran_done), 0);
        @(negedge clk);
        chk({tag, "_lat3"}, 32'(tran_done), 1);
        chk({tag, "_top"}, 32'(top_slot), 32'(t));
        chk({tag, "_bot"}, 32'(bot_slot), 32'(b));
        chk({tag, "_fy"}, 32'(fy), 32'(f));
        chk({tag, "_no_rd"}, 32'(rd_req), 0);
    endtask

    task automatic release_req(input string tag);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int td0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tran_done", 32'(tran_done), 0);
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_slots", 32'({top_slot, bot_slot}), 0);
        chk("rst_fy", 32'(fy), 0);
        rstn      = 1'b1;
        y_scale   = 15'h0400;
        src_v_num = 11'd360;
        src_h_num = 11'd640;
        @(negedge clk);

        // Stray rd_valid in IDLE must not write
        rd_valid = 1'b1;
        #1;
        chk("stray_valid_we", 32'(lb_we), 0);
        @(negedge clk);
        rd_valid = 1'b0;

        // dst 1 -> rows 0/1, both missing
        dst_row = 11'd1;
        wr_req  = 1'b1;
        td0     = td_cnt;
        serve("r1a", 0, 1'b0, 0, 0, -1);
        serve("r1b", 640, 1'b1, 0, 0, -1);
        done_after_fetch("r1", 1'b0, 1'b1, 11'h400);
        release_req("r1");
        chk("r1_td_once", 32'(td_cnt - td0), 1);

        // dst 2 -> rows 1/2, row 2 into slot 0, with grant stall and beat gaps
        dst_row = 11'd2;
        wr_req  = 1'b1;
        serve("r2", 1280, 1'b0, 10, 5, -1);
        done_after_fetch("r2", 1'b1, 1'b0, 11'h000);
        release_req("r2");

        // dst 3 -> full hit, then a held level must not retrigger
        td0 = td_cnt;
        req_hit("r3", 11'd3, 1'b1, 1'b0, 11'h400);
        repeat (20) @(negedge clk);
        chk("stale_td_count", 32'(td_cnt - td0), 1);
        chk("stale_busy", 32'(busy), 1);
        release_req("r3");
        req_hit("r3b", 11'd3, 1'b1, 1'b0, 11'h400);
        release_req("r3b");
        chk("r3_td_twice", 32'(td_cnt - td0), 2);

        // dst 719 -> sy 359 (not clamped), row pair collapses onto one slot
        dst_row = 11'd719;
        wr_req  = 1'b1;
        serve("r719", 359 * 640, 1'b0, 0, 0, -1);
        done_after_fetch("r719", 1'b0, 1'b0, 11'h400);
        release_req("r719");

        // dst 720 -> sy 360 clamped to 359, fy forced to 0, hit
        req_hit("r720", 11'd720, 1'b0, 1'b0, 11'h000);
        release_req("r720");

        // frame_start at beat 100: drain, return to IDLE, then refetch both rows
        dst_row = 11'd1;
        wr_req  = 1'b1;
        td0     = td_cnt;
        serve("fs", 0, 1'b0, 0, 0, 100);
        chk("fs_idle_after_drain", 32'(busy), 0);
        chk("fs_no_td", 32'(td_cnt - td0), 0);
        serve("fs_re_a", 0, 1'b0, 0, 0, -1);
        serve("fs_re_b", 640, 1'b1, 0, 0, -1);
        done_after_fetch("fs_re", 1'b0, 1'b1, 11'h400);
        release_req("fs_re");
        chk("fs_td_once", 32'(td_cnt - td0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
